gf_mult: RTL and testbench

//   Sequential GF(2^8) multiplier for the AES datapath (MixColumns / InvMixColumns).

---
 rtl/gf_mult.sv | 79 +++++++
 tb/tb_gf_mult.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mult.sv
// Sequential GF(2^8) multiplier used by the AES MixColumns datapath.
// Shift-and-add over a fixed 8 iterations with a start/busy/done handshake.
module gf_mult #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] val_a,
  input  logic [7:0] val_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] val_p
);

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] p_q, p_d;
  logic [3:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] val_p_q, val_p_d;

  // A start is only looked at while idle, so requests during an operation are dropped.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    val_p_d = val_p_q;
    if (!busy_q) begin
      if (start) begin
        a_d     = val_a;
        b_d     = val_b;
        p_d     = 8'h00;
        count_d = 4'd0;
        busy_d  = 1'b1;
      end
    end else begin
      p_d     = p_q ^ (b_q[0] ? a_q : 8'h00);
      a_d     = {a_q[6:0], 1'b0} ^ (a_q[7] ? POLY : 8'h00);
      b_d     = {1'b0, b_q[7:1]};
      count_d = count_q + 4'd1;
      // The eighth iteration publishes the accumulated product directly.
      if (count_q == 4'd7) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        val_p_d = p_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      p_q     <= 8'h00;
      count_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      val_p_q <= 8'h00;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      val_p_q <= val_p_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign val_p = val_p_q;

endmodule

// File: tb/tb_gf_mult.sv
// Self-checking bench for gf_mult: table vectors, handshake corner cases,
// mid-operation reset and randomised commutativity against a reference model.
module tb_gf_mult;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] val_a;
  logic [7:0] val_b;
  logic       busy;
  logic       done;
  logic [7:0] val_p;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[10];

  gf_mult #(.POLY(8'h1B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .val_a (val_a),
    .val_b (val_b),
    .busy  (busy),
    .done  (done),
    .val_p (val_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less 16-bit product reduced from the top bit down by 0x11B.
  function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (y[i]) prod = prod ^ (16'(x) << i);
    for (int k = 14; k >= 8; k--)
      if (prod[k]) prod = prod ^ (16'h011B << (k - 8));
    return prod[7:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drives one request (caller is between edges), pushes its expected product and
  // consumes the accept edge; inputs are scrambled afterwards since they must not matter.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit hold);
    start = 1'b1;
    val_a = a;
    val_b = b;
    exp_q.push_back(gf_ref(a, b));
    @(posedge clk);
    #1;
    chk("busy_after_accept", 16'(busy), 16'd1);
    if (!hold) start = 1'b0;
    val_a = 8'($urandom);
    val_b = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int lat);
    logic [7:0] expv;
    chk({name, "_latency"}, 16'(lat), 16'd8);
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 16'd1, 16'd0);
    end else begin
      expv = exp_q.pop_front();
      chk({name, "_product"}, 16'(val_p), 16'(expv));
    end
  endtask

  task automatic count_done_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [7:0] ra, rb, p_ab, p_ba;

    vecs[0] = '{8'h72, 8'h02, 8'hE4};
    vecs[1] = '{8'hE8, 8'h03, 8'h23};
    vecs[2] = '{8'hE8, 8'h02, 8'hCB};
    vecs[3] = '{8'h65, 8'h03, 8'hAF};
    vecs[4] = '{8'h65, 8'h02, 8'hCA};
    vecs[5] = '{8'h57, 8'h83, 8'hC1};
    vecs[6] = '{8'h57, 8'h13, 8'hFE};
    vecs[7] = '{8'h00, 8'hFF, 8'h00};
    vecs[8] = '{8'h01, 8'hAB, 8'hAB};
    vecs[9] = '{8'h02, 8'h80, 8'h1B};

    rst_n = 1'b0;
    start = 1'b0;
    val_a = 8'h00;
    val_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_val_p", 16'(val_p), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back with each start raised in the done cycle.
    foreach (vecs[i]) begin
      chk($sformatf("vec%0d_model", i), 16'(gf_ref(vecs[i].a, vecs[i].b)), 16'(vecs[i].p));
      exp_q.push_back(vecs[i].p);
      start = 1'b1;
      val_a = vecs[i].a;
      val_b = vecs[i].b;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), 16'(busy), 16'd1);
      start = 1'b0;
      val_a = 8'($urandom);
      val_b = 8'($urandom);
      void'(gf_ref(8'h00, 8'h00));
      exp_q.pop_back();
      exp_q.push_back(vecs[i].p);
      wait_done(lat);
      checkOutput($sformatf("vec%0d", i), lat);
    end

    // Single-cycle done pulse.
    @(posedge clk);
    #1;
    chk("done_single_pulse", 16'(done), 16'd0);
    chk("val_p_held", 16'(val_p), 16'h1B);

    // Start pulsed while busy with different operands must be ignored.
    @(negedge clk);
    applyStimulus(8'h57, 8'h83, 1'b0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (i == 2) begin
        start = 1'b1;
        val_a = 8'h12;
        val_b = 8'h34;
      end
      if (i == 5) start = 1'b0;
    end
    checkOutput("ignore_busy", lat);
    count_done_pulses(12, pulses);
    chk("ignore_busy_no_extra_done", 16'(pulses), 16'd0);

    // Reset asserted at iteration 4 aborts the operation.
    @(negedge clk);
    applyStimulus(8'h65, 8'h03, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_val_p", 16'(val_p), 16'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_done_pulses(12, pulses);
    chk("abort_no_done", 16'(pulses), 16'd0);
    chk("abort_val_p_after", 16'(val_p), 16'd0);
    @(negedge clk);
    applyStimulus(8'h03, 8'h05, 1'b0);
    wait_done(lat);
    checkOutput("after_reset", lat);
    chk("after_reset_const", 16'(val_p), 16'h0F);

    // Start held high: each op issues in the previous done cycle; commutativity check.
    @(negedge clk);
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (n == 0) begin ra = 8'hFF; rb = 8'hFF; end
      if (n == 1) begin ra = 8'h80; rb = 8'h80; end
      applyStimulus(ra, rb, 1'b1);
      wait_done(lat);
      p_ab = val_p;
      checkOutput($sformatf("rand%0d_ab", n), lat);
      applyStimulus(rb, ra, 1'b1);
      wait_done(lat);
      p_ba = val_p;
      checkOutput($sformatf("rand%0d_ba", n), lat);
      chk($sformatf("rand%0d_commute", n), 16'(p_ab), 16'(p_ba));
    end
    start = 1'b0;
    count_done_pulses(12, pulses);
    chk("final_idle_no_done", 16'(pulses), 16'd0);
    chk("final_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
